exu_mc: RTL and testbench

- Multi-cycle, parametrised execute unit for the single-clock core's next generation; sits between ID and MEM/WB.
- Performs the base integer ALU operations in one cycle.
- Performs RV32M-style multiply/divide iteratively.
- Uses valid/ready handshakes on input and output so the core can stall on long operations.
- Result and zero flag are registered; the front end holds the instruction while in_ready is low.

---
 rtl/exu_pkg.sv | 54 +++++
 rtl/exu_muldiv.sv | 99 +++++++++
 rtl/exu_mc.sv | 161 ++++++++++++++++
 tb/tb_exu_mc.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/exu_pkg.sv
// Shared types and decode helper for the multi-cycle execute unit.
// Latency: n/a (types and a combinational function only).
// Backpressure: n/a.
package exu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    // Encoded to match func3 of the M extension directly.
    typedef enum logic [2:0] {
        M_MUL = 3'b000, M_MULH = 3'b001, M_MULHSU = 3'b010, M_MULHU = 3'b011,
        M_DIV = 3'b100, M_DIVU = 3'b101, M_REM = 3'b110, M_REMU = 3'b111
    } m_op_e;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Address generation wins over everything; SUB only for R-type, since
    // a negative I-type immediate also sets func7_b5.
    function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic f7_b5,
                                           input logic r_type, input logic i_type,
                                           input logic b_type, input logic addr_type);
        alu_op_e op;
        op = ALU_ADD;
        if (addr_type) begin
            op = ALU_ADD;
        end else if (b_type) begin
            op = ALU_SUB;
        end else if (r_type | i_type) begin
            case (f3)
                F3_ADD:  op = (r_type & f7_b5) ? ALU_SUB : ALU_ADD;
                F3_SLL:  op = ALU_SLL;
                F3_SLT:  op = ALU_SLT;
                F3_SLTU: op = ALU_SLTU;
                F3_XOR:  op = ALU_XOR;
                F3_SR:   op = f7_b5 ? ALU_SRA : ALU_SRL;
                F3_OR:   op = ALU_OR;
                default: op = ALU_AND;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/exu_muldiv.sv
// Iterative multiply/divide engine, one bit per cycle; present only with EXU_MULDIV_EN.
// Latency: start plus DATAWIDTH cycles, done/result valid combinationally in the last one.
// Backpressure: none; the caller captures result on done, kill aborts at once.
`ifdef EXU_MULDIV_EN
module exu_muldiv
    import exu_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int CNTW      = $clog2(DATAWIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 kill,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic                 done,
    output logic [DATAWIDTH-1:0] result
);
    localparam int DW = DATAWIDTH;

    logic            run;
    logic [CNTW-1:0] cnt;
    m_op_e           op_r;
    logic            a_neg, b_neg, b_zero;
    logic [DW-1:0]   opnd;
    logic [2*DW-1:0] p, p_step, prod;
    logic            a_s, b_s, a_neg_in, b_neg_in;
    logic [DW-1:0]   ma, mb, quo, rem;
    logic [DW:0]     mul_sum, div_shift, div_diff;
    logic            div_ge;

    always_comb begin
        a_s = 1'b0;
        b_s = 1'b0;
        case (m_op_e'(op))
            M_MUL, M_MULH, M_DIV, M_REM: begin a_s = 1'b1; b_s = 1'b1; end
            M_MULHSU:                    a_s = 1'b1;
            default:                     ;
        endcase
    end

    assign a_neg_in = a_s & a[DW-1];
    assign b_neg_in = b_s & b[DW-1];
    assign ma = a_neg_in ? -a : a;
    assign mb = b_neg_in ? -b : b;

    // p holds {acc, multiplier} for MUL and {remainder, quotient} for DIV.
    assign mul_sum   = {1'b0, p[2*DW-1:DW]} + (p[0] ? {1'b0, opnd} : {(DW+1){1'b0}});
    assign div_shift = {p[2*DW-1:DW], p[DW-1]};
    assign div_diff  = div_shift - {1'b0, opnd};
    assign div_ge    = div_shift >= {1'b0, opnd};
    assign p_step    = op_r[2] ? {(div_ge ? div_diff[DW-1:0] : div_shift[DW-1:0]), p[DW-2:0], div_ge}
                               : {mul_sum, p[DW-1:1]};

    assign prod = (a_neg ^ b_neg) ? -p_step : p_step;
    assign quo  = b_zero ? {DW{1'b1}} : ((a_neg ^ b_neg) ? -p_step[DW-1:0] : p_step[DW-1:0]);
    assign rem  = a_neg ? -p_step[2*DW-1:DW] : p_step[2*DW-1:DW];

    always_comb begin
        case (op_r)
            M_MUL:                      result = prod[DW-1:0];
            M_MULH, M_MULHSU, M_MULHU:  result = prod[2*DW-1:DW];
            M_DIV, M_DIVU:              result = quo;
            default:                    result = rem;
        endcase
    end

    assign done = run & (cnt == CNTW'(DW - 1));

    always_ff @(posedge clk) begin
        if (rst || kill) begin
            run    <= 1'b0;
            cnt    <= '0;
            op_r   <= M_MUL;
            a_neg  <= 1'b0;
            b_neg  <= 1'b0;
            b_zero <= 1'b0;
            opnd   <= '0;
            p      <= '0;
        end else if (start) begin
            run    <= 1'b1;
            cnt    <= '0;
            op_r   <= m_op_e'(op);
            a_neg  <= a_neg_in;
            b_neg  <= b_neg_in;
            b_zero <= (b == '0);
            opnd   <= op[2] ? mb : ma;
            p      <= {{DW{1'b0}}, (op[2] ? ma : mb)};
        end else if (run) begin
            p   <= p_step;
            cnt <= cnt + CNTW'(1);
            if (done) run <= 1'b0;
        end
    end

endmodule
`endif

// File: rtl/exu_mc.sv
// Execute unit: 1-cycle base ALU, iterative M ops when EXU_MULDIV_EN is defined.
// Latency: 1 cycle for base ops, DATAWIDTH+1 for M ops; result registered.
// Backpressure: result held in DONE until out_ready; in_ready low while busy or stalled.
module exu_mc
    import exu_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int CNTW      = $clog2(DATAWIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    input  logic [DATAWIDTH-1:0] Rd_data1,
    input  logic [DATAWIDTH-1:0] Rd_data2,
    input  logic [DATAWIDTH-1:0] imme,
    input  logic [2:0]           func3,
    input  logic                 func7_b5,
    input  logic                 func7_b0,
    input  logic                 R_type,
    input  logic                 I_type,
    input  logic                 L_type,
    input  logic                 S_type,
    input  logic                 B_type,
    input  logic                 JALR_instr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] ALU_res,
    output logic                 ALU_ZERO,
    output logic                 busy
);
    localparam int DW  = DATAWIDTH;
    localparam int SHW = CNTW - 1;

    state_e        state, state_nxt;
    alu_op_e       alu_op;
    logic [DW-1:0] opb, alu_out, base_res;
    logic [SHW-1:0] shamt;
    logic          is_m, accept, load_base;

    assign is_m   = R_type & func7_b0;
    assign opb    = (R_type | B_type) ? Rd_data2 : imme;
    assign shamt  = opb[SHW-1:0];
    assign alu_op = alu_decode(func3, func7_b5, R_type, I_type, B_type,
                               L_type | S_type | JALR_instr);

    always_comb begin
        alu_out = '0;
        case (alu_op)
            ALU_ADD:  alu_out = Rd_data1 + opb;
            ALU_SUB:  alu_out = Rd_data1 - opb;
            ALU_SLL:  alu_out = Rd_data1 << shamt;
            ALU_SLT:  alu_out = {{(DW-1){1'b0}}, ($signed(Rd_data1) < $signed(opb))};
            ALU_SLTU: alu_out = {{(DW-1){1'b0}}, (Rd_data1 < opb)};
            ALU_XOR:  alu_out = Rd_data1 ^ opb;
            ALU_SRL:  alu_out = Rd_data1 >> shamt;
            ALU_SRA:  alu_out = $signed(Rd_data1) >>> shamt;
            ALU_OR:   alu_out = Rd_data1 | opb;
            default:  alu_out = Rd_data1 & opb;
        endcase
    end

    // Without the M datapath an M op still completes, with a zero result.
    assign base_res  = is_m ? '0 : alu_out;
    assign in_ready  = (state == S_IDLE) | ((state == S_DONE) & out_ready);
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid & in_ready;

`ifdef EXU_MULDIV_EN
    logic          md_start, md_done, load_md;
    logic [DW-1:0] md_res;

    exu_muldiv #(
        .DATAWIDTH (DATAWIDTH),
        .CNTW      (CNTW)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .kill   (flush),
        .start  (md_start),
        .op     (func3),
        .a      (Rd_data1),
        .b      (Rd_data2),
        .done   (md_done),
        .result (md_res)
    );

    assign busy = (state == S_MUL) | (state == S_DIV);
`else
    assign busy = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        load_base = 1'b0;
`ifdef EXU_MULDIV_EN
        md_start  = 1'b0;
        load_md   = 1'b0;
`endif
        case (state)
            S_IDLE, S_DONE: begin
                if (accept) begin
`ifdef EXU_MULDIV_EN
                    if (is_m) begin
                        md_start  = 1'b1;
                        state_nxt = func3[2] ? S_DIV : S_MUL;
                    end else begin
                        load_base = 1'b1;
                        state_nxt = S_DONE;
                    end
`else
                    load_base = 1'b1;
                    state_nxt = S_DONE;
`endif
                end else if ((state == S_DONE) && out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
`ifdef EXU_MULDIV_EN
            S_MUL, S_DIV: begin
                if (md_done) begin
                    load_md   = 1'b1;
                    state_nxt = S_DONE;
                end
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
        // Flush beats any accept or completion in the same cycle.
        if (flush) begin
            state_nxt = S_IDLE;
            load_base = 1'b0;
`ifdef EXU_MULDIV_EN
            md_start  = 1'b0;
            load_md   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            ALU_res  <= '0;
            ALU_ZERO <= 1'b1;
        end else begin
            state <= state_nxt;
            if (load_base) begin
                ALU_res  <= base_res;
                ALU_ZERO <= (base_res == '0);
            end
`ifdef EXU_MULDIV_EN
            else if (load_md) begin
                ALU_res  <= md_res;
                ALU_ZERO <= (md_res == '0);
            end
`endif
        end
    end

endmodule

// File: tb/tb_exu_mc.sv
// Directed bench for exu_mc at DATAWIDTH 32 and 16; M-op expectations follow EXU_MULDIV_EN.
module tb_exu_mc;
    import exu_pkg::*;

`ifdef EXU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    localparam logic [5:0] C_R = 6'b100000, C_I = 6'b010000, C_L = 6'b001000,
                           C_B = 6'b000010;

    logic        clk = 1'b0;
    logic        rst, in_valid, flush, out_ready;
    logic [2:0]  func3;
    logic        f7b5, f7b0, r_t, i_t, l_t, s_t, b_t, j_t;
    logic [31:0] d1, d2, imm;
    logic        in_ready, out_valid, zero, busy;
    logic [31:0] res;
    logic        in_ready16, out_valid16, zero16, busy16;
    logic [15:0] res16;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    exu_mc #(.DATAWIDTH(32)) u32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .Rd_data1(d1), .Rd_data2(d2), .imme(imm), .func3(func3),
        .func7_b5(f7b5), .func7_b0(f7b0), .R_type(r_t), .I_type(i_t), .L_type(l_t),
        .S_type(s_t), .B_type(b_t), .JALR_instr(j_t), .out_valid(out_valid),
        .out_ready(out_ready), .ALU_res(res), .ALU_ZERO(zero), .busy(busy)
    );

    exu_mc #(.DATAWIDTH(16)) u16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16), .flush(flush),
        .Rd_data1(d1[15:0]), .Rd_data2(d2[15:0]), .imme(imm[15:0]), .func3(func3),
        .func7_b5(f7b5), .func7_b0(f7b0), .R_type(r_t), .I_type(i_t), .L_type(l_t),
        .S_type(s_t), .B_type(b_t), .JALR_instr(j_t), .out_valid(out_valid16),
        .out_ready(out_ready), .ALU_res(res16), .ALU_ZERO(zero16), .busy(busy16)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [5:0] cls, input logic [2:0] f3, input logic f5,
                         input logic f0, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im);
        {r_t, i_t, l_t, s_t, b_t, j_t} = cls;
        func3 = f3; f7b5 = f5; f7b0 = f0;
        d1 = a; d2 = b; imm = im;
        in_valid = 1'b1;
    endtask

    task automatic m_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_m);
        int lat;
        int bcnt;
        lat = 0;
        bcnt = 0;
        drive(C_R, f3, 1'b0, 1'b1, a, b, 32'h0);
        step();
        in_valid = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            if (busy) bcnt++;
            if (out_valid) begin
                lat = n;
                break;
            end
            step();
        end
        chk({tag, "_lat"}, lat, MD ? 32'd33 : 32'd1);
        chk({tag, "_res"}, res, MD ? exp_m : 32'h0);
        chk({tag, "_busy"}, bcnt, MD ? 32'd32 : 32'd0);
        step();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        logic saw;
        int l16, l32;
        logic [31:0] r16, r32;

        rst = 1'b1; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
        drive(6'b0, 3'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        in_valid = 1'b0;
        step();
        step();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_res", res, 32'h0);
        chk("rst_zero", zero, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst16_zero", zero16, 1'b1);
        rst = 1'b0;

        // back-to-back base ops, one result per cycle
        drive(C_I, 3'b000, 1'b0, 1'b0, 32'd5, 32'h0, 32'hFFFF_FFFD);
        step();
        chk("addi_valid", out_valid, 1'b1);
        chk("addi_res", res, 32'd2);
        chk("addi_zero", zero, 1'b0);
        drive(C_I, 3'b100, 1'b0, 1'b0, 32'h0000_F0F0, 32'h0, 32'h0000_00FF);
        step();
        chk("xori_valid", out_valid, 1'b1);
        chk("xori_res", res, 32'h0000_F00F);
        drive(C_I, 3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'h0, 32'h0000_0424);
        step();
        chk("srai_res", res, 32'hF800_0000);
        drive(C_R, 3'b010, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0);
        step();
        chk("slt_res", res, 32'd1);
        drive(C_R, 3'b011, 1'b0, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'h0);
        step();
        chk("sltu_res", res, 32'd1);
        drive(C_R, 3'b000, 1'b1, 1'b0, 32'd3, 32'd5, 32'h0);
        step();
        chk("sub_res", res, 32'hFFFF_FFFE);
        drive(C_I, 3'b000, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 32'hFFFF_FC00);
        step();
        chk("addi_f7b5_res", res, 32'h0000_0C00);
        drive(C_L, 3'b010, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'hFFFF_FFFC);
        step();
        chk("load_addr_res", res, 32'h0000_00FC);
        drive(C_R, 3'b001, 1'b0, 1'b0, 32'd1, 32'h0000_0021, 32'h0);
        step();
        chk("sll_mask_res", res, 32'd2);
        in_valid = 1'b0;
        step();
        chk("drain_out_valid", out_valid, 1'b0);
        chk("drain_in_ready", in_ready, 1'b1);

        // branch compare, output held while out_ready low
        out_ready = 1'b0;
        drive(C_B, 3'b000, 1'b0, 1'b0, 32'h1234, 32'h1234, 32'h55);
        step();
        chk("beq_zero", zero, 1'b1);
        chk("beq_res", res, 32'h0);
        drive(C_I, 3'b000, 1'b0, 1'b0, 32'd1, 32'h0, 32'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_zero", zero, 1'b1);
            chk("hold_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", in_ready, 1'b1);
        step();
        chk("after_hold_res", res, 32'd2);
        in_valid = 1'b0;
        step();
        drive(C_B, 3'b000, 1'b0, 1'b0, 32'd5, 32'd3, 32'h0);
        step();
        chk("bne_zero", zero, 1'b0);
        in_valid = 1'b0;
        step();

        // flush in the same cycle as an accept
        flush = 1'b1;
        drive(C_I, 3'b000, 1'b0, 1'b0, 32'd7, 32'h0, 32'd1);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_acc_valid", out_valid, 1'b0);
        chk("flush_acc_in_ready", in_ready, 1'b1);

        // M extension
        m_op("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        m_op("mul_neg", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        m_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
        m_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        m_op("div_by0", 3'b100, 32'd7, 32'd0, 32'hFFFF_FFFF);
        m_op("rem_by0", 3'b110, 32'd7, 32'd0, 32'd7);
        m_op("rem_neg_by0", 3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
        m_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        m_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
        m_op("div_neg", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        m_op("rem_neg", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        m_op("divu", 3'b101, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF);
        m_op("remu", 3'b111, 32'd100, 32'd7, 32'd2);

        // flush on cycle 10 of a DIVU
        saw = 1'b0;
        drive(C_R, 3'b101, 1'b0, 1'b1, 32'd100, 32'd7, 32'h0);
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (out_valid) saw = 1'b1;
            step();
        end
        if (out_valid) saw = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_busy", busy, 1'b0);
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_in_ready", in_ready, 1'b1);
        chk("flush_saw_valid", saw, MD ? 1'b0 : 1'b1);
        drive(C_I, 3'b000, 1'b0, 1'b0, 32'd1, 32'h0, 32'd1);
        step();
        in_valid = 1'b0;
        chk("post_flush_valid", out_valid, 1'b1);
        chk("post_flush_res", res, 32'd2);
        step();

        // reset in the middle of a MUL
        drive(C_R, 3'b000, 1'b0, 1'b1, 32'd7, 32'd3, 32'h0);
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("mid_mul_busy", busy, MD ? 1'b1 : 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mul_res", res, 32'h0);
        chk("rst_mul_zero", zero, 1'b1);
        chk("rst_mul_valid", out_valid, 1'b0);
        chk("rst_mul_busy", busy, 1'b0);
        chk("rst_mul_in_ready", in_ready, 1'b1);

        // MUL 0xFFFF x 0xFFFF on both widths
        l16 = 0; l32 = 0; r16 = '0; r32 = '0;
        drive(C_R, 3'b000, 1'b0, 1'b1, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0);
        step();
        in_valid = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            if (l16 == 0 && out_valid16) begin l16 = n; r16 = {16'h0, res16}; end
            if (l32 == 0 && out_valid) begin l32 = n; r32 = res; end
            if (l16 != 0 && l32 != 0) break;
            step();
        end
        chk("mul16_lat", l16, MD ? 32'd17 : 32'd1);
        chk("mul16_res", r16, MD ? 32'h0000_0001 : 32'h0);
        chk("mul32_ffff_lat", l32, MD ? 32'd33 : 32'd1);
        chk("mul32_ffff_res", r32, MD ? 32'hFFFE_0001 : 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
